// File: rtl/gather_pkg.sv
// Shared types and constants for the gather router output controller.
package gather_pkg;

    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_e;

    // Width needed to hold a credit count in the range 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gather_output_controller_rr_arbiter.sv
// N-wide round-robin arbiter: combinational grant from a registered pointer
// that moves to one past the winner whenever a grant is taken.
module gather_rr_arbiter #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] win;
    logic          found;
    int unsigned   idx;

    always_comb begin
        grant = '0;
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/gather_output_controller.sv
// Output-port VC allocator with per-VC ownership and credit tracking.
// Define GOC_ATOMIC_VC_EN to grant a VC only once its downstream buffer is drained.
module gather_output_controller
    import gather_pkg::*;
#(
    parameter int unsigned NI        = 5,
    parameter int unsigned CN        = 5,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NI*CN-1:0] req_vc,
    output logic [NI-1:0]    vc_granted,
    output logic [NI*CN-1:0] sel_out_vc,
    input  logic             out_flit_fire,
    input  logic [CN-1:0]    out_flit_vc,
    input  logic [1:0]       out_flit_type,
    input  logic [CN-1:0]    credit_in,
    output logic [CN-1:0]    credit_avail,
    output logic [CN-1:0]    vc_busy,
    output logic             err_credit
);

    localparam int unsigned     CW       = credit_width(BUF_DEPTH);
    localparam logic [CW-1:0]   CRED_MAX = CW'(BUF_DEPTH);

    logic [CN-1:0] grantable;
    logic [CN-1:0] alloc_vc;
    logic [CN-1:0] err_vec;
    logic [NI-1:0] eligible;
    logic [CN-1:0] masked;
    logic [CN-1:0] lowbit;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NI; i++) begin
            eligible[i] = |(req_vc[i*CN +: CN] & grantable);
        end
    end

    gather_rr_arbiter #(.N(NI)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (eligible),
        .advance (|vc_granted),
        .grant   (vc_granted)
    );

    // Winner takes the lowest-index VC it asked for that is currently grantable.
    always_comb begin
        sel_out_vc = '0;
        alloc_vc   = '0;
        masked     = '0;
        lowbit     = '0;
        for (int unsigned i = 0; i < NI; i++) begin
            masked = req_vc[i*CN +: CN] & grantable;
            lowbit = masked & (~masked + CN'(1));
            if (vc_granted[i]) begin
                sel_out_vc[i*CN +: CN] = lowbit;
                alloc_vc               = alloc_vc | lowbit;
            end
        end
    end

    for (genvar v = 0; v < CN; v++) begin : g_vc
        vc_state_e     state_q, state_d;
        logic [CW-1:0] cred_q;
        logic          dec, inc;

        assign dec = out_flit_fire & out_flit_vc[v];
        assign inc = credit_in[v];

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                VC_IDLE:   if (alloc_vc[v]) state_d = VC_ACTIVE;
                VC_ACTIVE: if (dec && out_flit_type == FLIT_TAIL) state_d = VC_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) state_q <= VC_IDLE;
            else     state_q <= state_d;
        end

        // Simultaneous fire and credit return cancel; counts saturate at both ends.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cred_q <= CRED_MAX;
            end else if (dec && !inc) begin
                if (cred_q != '0) cred_q <= cred_q - 1'b1;
            end else if (inc && !dec) begin
                if (cred_q != CRED_MAX) cred_q <= cred_q + 1'b1;
            end
        end

        assign err_vec[v]      = (dec && !inc && cred_q == '0) ||
                                 (inc && !dec && cred_q == CRED_MAX);
        assign vc_busy[v]      = (state_q == VC_ACTIVE);
        assign credit_avail[v] = (cred_q != '0);
`ifdef GOC_ATOMIC_VC_EN
        assign grantable[v]    = (state_q == VC_IDLE) && (cred_q == CRED_MAX);
`else
        assign grantable[v]    = (state_q == VC_IDLE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           err_credit <= 1'b0;
        else if (|err_vec) err_credit <= 1'b1;
    end

endmodule
